// File: rtl/dec_rr_sched_if.sv
// Bus between the requester logic and the round-robin decoder scheduler.
//   master (requester side): drives en, req, dwell; observes grant outputs.
//   slave  (scheduler side): observes en, req, dwell; drives sel, onehot,
//                            grant_valid, ack, busy_cnt.
interface dec_rr_sched_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               en;
    logic [7:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic [7:0]         onehot;
    logic               grant_valid;
    logic [7:0]         ack;
    logic [DWELL_W-1:0] busy_cnt;

    modport master (
        output en, req, dwell,
        input  sel, onehot, grant_valid, ack, busy_cnt
    );

    modport slave (
        input  en, req, dwell,
        output sel, onehot, grant_valid, ack, busy_cnt
    );
endinterface

// File: rtl/dec_rr_sched.sv
// Round-robin scheduler sharing a 3-to-8 one-hot decoder among eight requesters.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - dec_rr_sched_if.slave: en/req/dwell in; sel/onehot/grant_valid/
//            ack/busy_cnt out (all outputs registered)
module dec_rr_sched #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dec_rr_sched_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_t             state, state_n;
    logic [2:0]         sel_q, sel_n;
    logic [2:0]         last_q, last_n;
    logic [7:0]         onehot_q, onehot_n;
    logic [7:0]         ack_q, ack_n;
    logic               gv_q, gv_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;

    logic [2:0]         win;
    logic               win_found;
    logic [2:0]         idx;

    // Scan last+1 .. last+8 (mod 8); the first set request wins.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!win_found && bus.req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel_q;
        last_n   = last_q;
        onehot_n = onehot_q;
        gv_n     = gv_q;
        cnt_n    = cnt_q;
        ack_n    = '0;
        case (state)
            IDLE: begin
                if (bus.en && win_found) begin
                    state_n  = HOLD;
                    sel_n    = win;
                    onehot_n = 8'b1 << win;
                    gv_n     = 1'b1;
                    cnt_n    = (bus.dwell == '0) ? CNT_ONE : bus.dwell;
                end
            end
            HOLD: begin
                if (!bus.req[sel_q]) begin
                    // Withdrawn: abort without ack; requester still loses its turn.
                    state_n  = IDLE;
                    last_n   = sel_q;
                    onehot_n = '0;
                    gv_n     = 1'b0;
                    cnt_n    = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_n  = IDLE;
                    last_n   = sel_q;
                    ack_n    = 8'b1 << sel_q;
                    onehot_n = '0;
                    gv_n     = 1'b0;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            last_q   <= 3'd7;
            onehot_q <= '0;
            ack_q    <= '0;
            gv_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            last_q   <= last_n;
            onehot_q <= onehot_n;
            ack_q    <= ack_n;
            gv_q     <= gv_n;
            cnt_q    <= cnt_n;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.onehot      = onehot_q;
    assign bus.grant_valid = gv_q;
    assign bus.ack         = ack_q;
    assign bus.busy_cnt    = cnt_q;
endmodule
